adj_walk_ctrl: RTL and testbench
================================

// Module: adj_walk_ctrl
// PURPOSE
//  Sequences one graph-walk pass for the path-count datapath. Pops ready node indices
//  from the work FIFO and fetches each node's {base,count} from the adjacency meta
//  table. Walks its child list in the child table and hands each child edge to the
//  accumulator datapath with a valid/ready handshake. Sits between the FIFO/ROMs and
//  the accumulator; raises done_reg when no work remains.
// PARAMETERS
//  PARAM_NODE_IDX_WIDTH  10  node index width
//  PARAM_COUNTER_WIDTH    5  child ordinal/count width (max 31 children per node)
//  PARAM_ADJ_ADDR_WIDTH  11  child-table address width
// PORTS
//  clk                in   1     single clock, rising edge
//  rst_n              in   1     synchronous, active-low reset
//  start_run          in   1     start pass; sampled only in IDLE
//  fifo_empty         in   1     work FIFO empty
//  fifo_rd_data       in   NIW   FIFO head, first-word-fall-through
//  fifo_pop           out  1     pop FIFO head this cycle
//  meta_rd_en         out  1     meta-table read strobe
//  meta_rd_addr       out  NIW   meta-table address (= node index)
//  meta_rd_data       in   AAW+CW  {base,count}; valid 1 cycle after meta_rd_en
//  child_rd_en        out  1     child-table read strobe
//  child_rd_addr      out  AAW   child-table address
//  child_rd_data      in   NIW   child node index; valid 1 cycle after child_rd_en
//  acc_busy           in   1     accumulator may still push into the FIFO
//  node_idx_reg       out  NIW   node currently being expanded
//  edge_valid         out  1     edge {node_idx_reg -> next_node_idx} offered
//  edge_ready         in   1     accumulator accepts edge
//  rd_next_node_reg   out  1     registered pulse: edge accepted last cycle
//  next_node_idx      out  NIW   child node of offered edge
//  next_node_counter  out  CW    child ordinal k (0..count-1)
//  busy               out  1     pass in progress
//  done_reg           out  1     pass complete; held until next start_run
//  stat_nodes         out  NIW+1 nodes expanded (see CONFIGURATION)
//  stat_edges         out  AAW+1 edges accepted (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE; every output 0. Reset mid-pass aborts it; no pop until next start.
//  Reset clears done_reg. A done_reg from an earlier pass also clears.
//  IDLE: start_run=1 -> clear done_reg, busy=1, go POP. start_run outside IDLE ignored.
//  POP: !fifo_empty -> fifo_pop=1, meta_rd_en=1, meta_rd_addr=fifo_rd_data.
//    Same cycle: node_idx_reg<=fifo_rd_data; go META.
//    fifo_empty & !acc_busy & !edge_valid -> go DONE. fifo_empty & acc_busy -> wait in POP.
//  META: latch base,count, k<=0. count==0 -> POP. Else child_rd_en=1, addr=base; go EMIT.
//  EMIT: from the cycle after the read, edge_valid=1, next_node_idx=child_rd_data (registered).
//    next_node_counter=k. Fields held stable while edge_valid & !edge_ready.
//    No new child read while stalled.
//    On edge_valid&edge_ready: k==count-1 -> POP.
//    Else k<=k+1, issue read at base+k+1; edge_valid drops 1 cycle.
//    Throughput: 2 cycles per edge.
//  DONE: done_reg<=1, busy<=0 -> IDLE. done_reg stays 1 until start_run or reset.
//  rd_next_node_reg: 1 exactly the cycle after each accepted edge.
//  child_rd_addr = base + k in AAW bits. Table contents keep base+count-1 <= 2^AAW-1.
//  No wrap check in RTL.
//  Meta-table data layout: {base[AAW-1:0], count[CW-1:0]}.
// CONFIGURATION
//  ADJ_WALK_STATS_EN defined:
//    stat_nodes increments on each fifo_pop. stat_edges increments on each accepted edge.
//    Both saturate at all-ones. Both clear on start_run in IDLE and on reset.
//  Undefined: stat_nodes and stat_edges tied to 0; ports remain present.
// STRUCTURE
//  aoc_graph_pkg: width localparams (NIW, CW, AAW).
//  aoc_graph_pkg: walk_state_t enum {IDLE,POP,META,EMIT,DONE}.
//  aoc_graph_pkg: meta-field slice helper.
//  One sub-module: edge_out_slice, the output register holding edge fields.
//  edge_out_slice holds next_node_idx, next_node_counter and edge_valid stable under backpressure.
// TESTING
//  1 Reset held 3 cycles then released -> all outputs 0; state IDLE; no fifo_pop.
//  2 FIFO={5}, meta[5]={10,3}, child[10..12]={7,8,9}, edge_ready=1, start_run pulse:
//    edges 5->7,5->8,5->9 with counter 0,1,2; 3 rd_next_node_reg pulses.
//    done_reg=1 after FIFO drains with acc_busy=0.
//  3 Same as 2 with edge_ready low 4 cycles on the 1st edge -> next_node_idx=7 stable.
//    Only one child read issued; sequence otherwise identical.
//  4 meta[5]={0,0} leaf -> no edge_valid; immediate next pop or DONE.
//  5 FIFO empties while acc_busy=1 -> no done_reg.
//    Push node 8 (meta {20,1}, child[20]=3) -> edge 8->3; then done_reg.
//  6 rst_n low during EMIT -> next cycle all outputs 0.
//    No fifo_pop until a new start_run.
//  7 (ADJ_WALK_STATS_EN) after scenario 2 -> stat_nodes=1, stat_edges=3.

Source files
------------

// File: rtl/aoc_graph_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aoc_graph_pkg
// Brief    : Shared widths, walk FSM state type and meta-word field helpers
//            for the path-count graph walk.
// Revision : 1.0  initial release
// ============================================================================
package aoc_graph_pkg;

    localparam int NIW = 10;  // node index width
    localparam int CW  = 5;   // child ordinal / count width
    localparam int AAW = 11;  // child-table address width

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        POP  = 3'd1,
        META = 3'd2,
        EMIT = 3'd3,
        DONE = 3'd4
    } walk_state_t;

    // Meta word layout is {base, count}; base sits in the upper AAW bits.
    function automatic logic [AAW-1:0] meta_base(input logic [AAW+CW-1:0] meta);
        return meta[AAW+CW-1:CW];
    endfunction

    function automatic logic [CW-1:0] meta_count(input logic [AAW+CW-1:0] meta);
        return meta[CW-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/adj_walk_ctrl_edge_out_slice.sv
`default_nettype none
// ============================================================================
// Module   : edge_out_slice
// Brief    : Output register for the offered edge. Loads child index and
//            ordinal, raises valid, and holds all fields until accepted.
// Revision : 1.0  initial release
// ============================================================================
module edge_out_slice
    import aoc_graph_pkg::*;
#(
    parameter int IDX_W = NIW,
    parameter int CNT_W = CW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             accept,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [CNT_W-1:0] load_cnt,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [CNT_W-1:0] cnt
);

    // Capture a fresh edge on load; drop valid on acceptance; otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            idx   <= '0;
            cnt   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            idx   <= load_idx;
            cnt   <= load_cnt;
        end else if (accept) begin
            valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adj_walk_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adj_walk_ctrl
// Brief    : Sequences one graph-walk pass: pops node indices from the work
//            FIFO, fetches {base,count} from the meta table, walks the child
//            list and offers each edge to the accumulator via valid/ready.
//            Optional statistics counters enabled by ADJ_WALK_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
module adj_walk_ctrl
    import aoc_graph_pkg::*;
#(
    parameter int PARAM_NODE_IDX_WIDTH = NIW,
    parameter int PARAM_COUNTER_WIDTH  = CW,
    parameter int PARAM_ADJ_ADDR_WIDTH = AAW
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              start_run,
    input  logic                                              fifo_empty,
    input  logic [PARAM_NODE_IDX_WIDTH-1:0]                   fifo_rd_data,
    output logic                                              fifo_pop,
    output logic                                              meta_rd_en,
    output logic [PARAM_NODE_IDX_WIDTH-1:0]                   meta_rd_addr,
    input  logic [PARAM_ADJ_ADDR_WIDTH+PARAM_COUNTER_WIDTH-1:0] meta_rd_data,
    output logic                                              child_rd_en,
    output logic [PARAM_ADJ_ADDR_WIDTH-1:0]                   child_rd_addr,
    input  logic [PARAM_NODE_IDX_WIDTH-1:0]                   child_rd_data,
    input  logic                                              acc_busy,
    output logic [PARAM_NODE_IDX_WIDTH-1:0]                   node_idx_reg,
    output logic                                              edge_valid,
    input  logic                                              edge_ready,
    output logic                                              rd_next_node_reg,
    output logic [PARAM_NODE_IDX_WIDTH-1:0]                   next_node_idx,
    output logic [PARAM_COUNTER_WIDTH-1:0]                    next_node_counter,
    output logic                                              busy,
    output logic                                              done_reg,
    output logic [PARAM_NODE_IDX_WIDTH:0]                     stat_nodes,
    output logic [PARAM_ADJ_ADDR_WIDTH:0]                     stat_edges
);

    localparam int NW  = PARAM_NODE_IDX_WIDTH;
    localparam int CNT = PARAM_COUNTER_WIDTH;
    localparam int AW  = PARAM_ADJ_ADDR_WIDTH;
    localparam logic [CNT-1:0] ONE_CNT  = 1;
    localparam logic [AW-1:0]  ONE_ADDR = 1;

    walk_state_t      state;
    walk_state_t      state_nxt;
    logic [AW-1:0]    base_r;
    logic [CNT-1:0]   count_r;
    logic [CNT-1:0]   k_r;
    logic             rd_pend;    // child read in flight; data arrives this cycle
    logic             accept;
    logic             last_edge;
    logic             slice_load;
    logic             start_pass;

    assign accept    = edge_valid & edge_ready;
    assign last_edge = (k_r == (count_r - ONE_CNT));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and table/FIFO strobes.
    always_comb begin
        state_nxt     = state;
        fifo_pop      = 1'b0;
        meta_rd_en    = 1'b0;
        meta_rd_addr  = '0;
        child_rd_en   = 1'b0;
        child_rd_addr = '0;
        slice_load    = 1'b0;
        start_pass    = 1'b0;
        case (state)
            IDLE: begin
                if (start_run) begin
                    start_pass = 1'b1;
                    state_nxt  = POP;
                end
            end
            POP: begin
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    meta_rd_en   = 1'b1;
                    meta_rd_addr = fifo_rd_data;
                    state_nxt    = META;
                end else if (!acc_busy && !edge_valid) begin
                    state_nxt = DONE;
                end
            end
            META: begin
                if (meta_count(meta_rd_data) == '0) begin
                    state_nxt = POP;
                end else begin
                    child_rd_en   = 1'b1;
                    child_rd_addr = meta_base(meta_rd_data);
                    state_nxt     = EMIT;
                end
            end
            EMIT: begin
                if (rd_pend) begin
                    slice_load = 1'b1;
                end else if (accept) begin
                    if (last_edge) begin
                        state_nxt = POP;
                    end else begin
                        // Next child sits at base + (k + 1).
                        child_rd_en   = 1'b1;
                        child_rd_addr = base_r + AW'(k_r) + ONE_ADDR;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Node/child-list bookkeeping, pass status and acceptance pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            node_idx_reg     <= '0;
            base_r           <= '0;
            count_r          <= '0;
            k_r              <= '0;
            rd_pend          <= 1'b0;
            rd_next_node_reg <= 1'b0;
            busy             <= 1'b0;
            done_reg         <= 1'b0;
        end else begin
            rd_next_node_reg <= accept;
            if (start_pass) begin
                done_reg <= 1'b0;
                busy     <= 1'b1;
            end
            if (state == DONE) begin
                done_reg <= 1'b1;
                busy     <= 1'b0;
            end
            if (fifo_pop) begin
                node_idx_reg <= fifo_rd_data;
            end
            if (state == META) begin
                base_r  <= meta_base(meta_rd_data);
                count_r <= meta_count(meta_rd_data);
                k_r     <= '0;
                rd_pend <= (meta_count(meta_rd_data) != '0);
            end
            if (state == EMIT) begin
                if (rd_pend) begin
                    rd_pend <= 1'b0;
                end else if (accept && !last_edge) begin
                    k_r     <= k_r + ONE_CNT;
                    rd_pend <= 1'b1;
                end
            end
        end
    end

    edge_out_slice #(
        .IDX_W (NW),
        .CNT_W (CNT)
    ) u_edge_out_slice (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (slice_load),
        .accept   (accept),
        .load_idx (child_rd_data),
        .load_cnt (k_r),
        .valid    (edge_valid),
        .idx      (next_node_idx),
        .cnt      (next_node_counter)
    );

`ifdef ADJ_WALK_STATS_EN
    // Saturating counts of expanded nodes and accepted edges for this pass.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_nodes <= '0;
            stat_edges <= '0;
        end else if (start_pass) begin
            stat_nodes <= '0;
            stat_edges <= '0;
        end else begin
            if (fifo_pop && (stat_nodes != '1)) begin
                stat_nodes <= stat_nodes + 1'b1;
            end
            if (accept && (stat_edges != '1)) begin
                stat_edges <= stat_edges + 1'b1;
            end
        end
    end
`else
    assign stat_nodes = '0;
    assign stat_edges = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adj_walk_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adj_walk_ctrl
// Brief    : Self-checking bench for adj_walk_ctrl: directed scenarios plus
//            randomized graphs checked against an edge-list reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_adj_walk_ctrl;

    localparam int NIW = 10;
    localparam int CW  = 5;
    localparam int AAW = 11;

    logic                clk        = 1'b0;
    logic                rst_n      = 1'b0;
    logic                start_run  = 1'b0;
    logic                acc_busy   = 1'b0;
    logic                edge_ready = 1'b0;
    logic                fifo_empty;
    logic [NIW-1:0]      fifo_rd_data;
    logic                fifo_pop;
    logic                meta_rd_en;
    logic [NIW-1:0]      meta_rd_addr;
    logic [AAW+CW-1:0]   meta_q;
    logic                child_rd_en;
    logic [AAW-1:0]      child_rd_addr;
    logic [NIW-1:0]      child_q;
    logic [NIW-1:0]      node_idx_reg;
    logic                edge_valid;
    logic                rd_next_node_reg;
    logic [NIW-1:0]      next_node_idx;
    logic [CW-1:0]       next_node_counter;
    logic                busy;
    logic                done_reg;
    logic [NIW:0]        stat_nodes;
    logic [AAW:0]        stat_edges;

    always #5 clk = ~clk;

    adj_walk_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start_run         (start_run),
        .fifo_empty        (fifo_empty),
        .fifo_rd_data      (fifo_rd_data),
        .fifo_pop          (fifo_pop),
        .meta_rd_en        (meta_rd_en),
        .meta_rd_addr      (meta_rd_addr),
        .meta_rd_data      (meta_q),
        .child_rd_en       (child_rd_en),
        .child_rd_addr     (child_rd_addr),
        .child_rd_data     (child_q),
        .acc_busy          (acc_busy),
        .node_idx_reg      (node_idx_reg),
        .edge_valid        (edge_valid),
        .edge_ready        (edge_ready),
        .rd_next_node_reg  (rd_next_node_reg),
        .next_node_idx     (next_node_idx),
        .next_node_counter (next_node_counter),
        .busy              (busy),
        .done_reg          (done_reg),
        .stat_nodes        (stat_nodes),
        .stat_edges        (stat_edges)
    );

    // ---------------- environment: tables and FWFT FIFO ----------------
    logic [AAW+CW-1:0] meta_tab  [0:1023];
    logic [NIW-1:0]    child_tab [0:2047];
    logic [NIW-1:0]    fifo_mem  [0:1023];
    int unsigned       wr_ptr = 0;
    int unsigned       rd_ptr = 0;

    assign fifo_empty   = (rd_ptr == wr_ptr);
    assign fifo_rd_data = fifo_mem[rd_ptr % 1024];

    always @(posedge clk) begin
        if (fifo_pop)    rd_ptr  <= rd_ptr + 1;
        if (meta_rd_en)  meta_q  <= meta_tab[meta_rd_addr];
        if (child_rd_en) child_q <= child_tab[child_rd_addr];
    end

    // ---------------- reference model: expected edge list ----------------
    typedef struct {
        logic [NIW-1:0] node;
        logic [NIW-1:0] child;
        logic [CW-1:0]  k;
    } edge_t;
    edge_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: stall budget
    int stall_left = 0;
    int cyc = 0;
    int n_pops = 0, n_child = 0, n_acc = 0;
    int acc_cycles[$];
    bit prev_stalled = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every node expands to edges (node, child[base+k], k) for k in 0..count-1.
    task automatic model_node(input logic [NIW-1:0] n);
        logic [AAW+CW-1:0] m;
        int base, cnt;
        m    = meta_tab[n];
        base = int'(m) / 32;
        cnt  = int'(m) % 32;
        for (int k = 0; k < cnt; k++) begin
            edge_t e;
            e.node  = n;
            e.child = child_tab[(base + k) % 2048];
            e.k     = CW'(k);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_node(input logic [NIW-1:0] n);
        fifo_mem[wr_ptr % 1024] = n;
        wr_ptr = wr_ptr + 1;
        model_node(n);
    endtask

    function automatic logic [AAW+CW-1:0] mk_meta(input int base, input int cnt);
        return (AAW+CW)'(base * 32 + cnt);
    endfunction

    task automatic clear_counts();
        n_pops = 0; n_child = 0; n_acc = 0;
        acc_cycles.delete();
    endtask

    // One clock: entered and left at a falling edge.
    task automatic cycle();
        bit acc;
        bit rst_before;
        case (ready_mode)
            0: edge_ready = 1'b1;
            1: edge_ready = ($urandom_range(0, 2) != 0);
            default: begin
                if (edge_valid && stall_left > 0) begin
                    edge_ready = 1'b0;
                    stall_left--;
                end else begin
                    edge_ready = 1'b1;
                end
            end
        endcase
        if (prev_stalled) chk("valid_held", edge_valid, 1);
        if (edge_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_edge", edge_valid, 0);
            end else begin
                chk("edge_src", node_idx_reg, exp_q[0].node);
                chk("edge_dst", next_node_idx, exp_q[0].child);
                chk("edge_k", next_node_counter, exp_q[0].k);
            end
        end
        rst_before   = rst_n;
        acc          = edge_valid && edge_ready && rst_n;
        prev_stalled = edge_valid && !edge_ready && rst_n;
        if (acc && exp_q.size() > 0) begin
            exp_q.delete(0);
            n_acc++;
            acc_cycles.push_back(cyc);
        end
        if (fifo_pop) n_pops++;
        if (child_rd_en) n_child++;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (rst_before) chk("rd_next_pulse", rd_next_node_reg, acc);
    endtask

    task automatic start_pass();
        clear_counts();
        start_run = 1'b1;
        cycle();
        start_run = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while (!done_reg && i < budget) begin
            cycle();
            i++;
        end
        chk("done_reached", done_reg, 1);
        chk("model_drained", exp_q.size(), 0);
        chk("busy_low", busy, 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk(tag, |{fifo_pop, meta_rd_en, meta_rd_addr, child_rd_en, child_rd_addr,
                   node_idx_reg, edge_valid, rd_next_node_reg, next_node_idx,
                   next_node_counter, busy, done_reg, stat_nodes, stat_edges}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) meta_tab[i] = '0;
        for (int i = 0; i < 2048; i++) child_tab[i] = '0;
        meta_tab[5]   = mk_meta(10, 3);
        child_tab[10] = 10'd7;
        child_tab[11] = 10'd8;
        child_tab[12] = 10'd9;

        // 1: reset held 3 cycles with work waiting; nothing may move.
        push_node(10'd5);
        @(negedge clk);
        repeat (3) cycle();
        chk_outputs_zero("reset_outputs");
        rst_n = 1'b1;
        clear_counts();
        repeat (3) cycle();
        chk_outputs_zero("idle_outputs");
        chk("idle_no_pop", n_pops, 0);

        // 2: single node, three children, always ready.
        ready_mode = 0;
        start_pass();
        chk("busy_after_start", busy, 1);
        wait_done(100);
        chk("s2_edges", n_acc, 3);
        chk("s2_pops", n_pops, 1);
        chk("s2_child_reads", n_child, 3);
        if (acc_cycles.size() == 3) begin
            chk("s2_gap01", acc_cycles[1] - acc_cycles[0], 2);
            chk("s2_gap12", acc_cycles[2] - acc_cycles[1], 2);
        end else begin
            chk("s2_accept_count", acc_cycles.size(), 3);
        end
`ifdef ADJ_WALK_STATS_EN
        chk("stat_nodes", stat_nodes, 1);
        chk("stat_edges", stat_edges, 3);
`else
        chk("stat_nodes_off", stat_nodes, 0);
        chk("stat_edges_off", stat_edges, 0);
`endif
        repeat (3) cycle();
        chk("done_held", done_reg, 1);

        // 3: backpressure on the first edge for 4 cycles.
        push_node(10'd5);
        ready_mode = 2;
        stall_left = 4;
        start_pass();
        chk("done_cleared_on_start", done_reg, 0);
        wait_done(100);
        chk("s3_edges", n_acc, 3);
        chk("s3_child_reads", n_child, 3);
        chk("s3_stall_used", stall_left, 0);

        // 4: leaf node produces no edges.
        ready_mode = 0;
        meta_tab[5] = mk_meta(0, 0);
        push_node(10'd5);
        start_pass();
        wait_done(50);
        chk("s4_pops", n_pops, 1);
        chk("s4_child_reads", n_child, 0);
        chk("s4_edges", n_acc, 0);
        meta_tab[5] = mk_meta(10, 3);

        // 5: accumulator still busy keeps the pass open for late work.
        acc_busy = 1'b1;
        meta_tab[8]   = mk_meta(20, 1);
        child_tab[20] = 10'd3;
        push_node(10'd5);
        start_pass();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) cycle();
        repeat (10) cycle();
        chk("s5_no_done_busy", done_reg, 0);
        chk("s5_busy_held", busy, 1);
        push_node(10'd8);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) cycle();
        chk("s5_late_edge", exp_q.size(), 0);
        chk("s5_still_open", done_reg, 0);
        acc_busy = 1'b0;
        wait_done(20);
        chk("s5_edges", n_acc, 4);

        // 6: reset while an edge is stalled in EMIT.
        meta_tab[6]   = mk_meta(30, 2);
        child_tab[30] = 10'd100;
        child_tab[31] = 10'd101;
        push_node(10'd5);
        push_node(10'd6);
        ready_mode = 2;
        stall_left = 1000;
        start_pass();
        for (int i = 0; i < 20 && !edge_valid; i++) cycle();
        chk("s6_reached_emit", edge_valid, 1);
        rst_n = 1'b0;
        cycle();
        chk_outputs_zero("s6_reset_outputs");
        rst_n = 1'b1;
        ready_mode = 0;
        stall_left = 0;
        exp_q.delete();
        for (int unsigned p = rd_ptr; p != wr_ptr; p++) model_node(fifo_mem[p % 1024]);
        clear_counts();
        repeat (5) cycle();
        chk("s6_no_pop_after_reset", n_pops, 0);
        chk("s6_idle_busy", busy, 0);
        start_pass();
        wait_done(50);
        chk("s6_remaining_edges", n_acc, 2);

        // Randomized graphs with random backpressure.
        ready_mode = 1;
        for (int pass = 0; pass < 4; pass++) begin
            int nodes[6];
            for (int j = 0; j < 6; j++) begin
                int base, cnt;
                nodes[j] = $urandom_range(100, 900);
                base     = $urandom_range(0, 2040);
                cnt      = $urandom_range(0, 5);
                meta_tab[nodes[j]] = mk_meta(base, cnt);
                for (int k = 0; k < cnt; k++) child_tab[base + k] = NIW'($urandom);
            end
            for (int j = 0; j < 6; j++) push_node(NIW'(nodes[j]));
            start_pass();
            wait_done(600);
            chk("rnd_pops", n_pops, 6);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
